align_sequencer: RTL and testbench
==================================

# align_sequencer

Multi-cycle exponent-alignment controller for the floating-point pre-adder. It accepts an operand pair (8-bit exponent, 28-bit mantissa each) and selects the larger-exponent operand. It right-shifts the other mantissa by the exponent difference, at most STEP bits per cycle, with sticky-bit accumulation, using a single narrow shift stage over several cycles. The aligned pair and the common exponent are presented to the adder stage through a valid/ready handshake.

## Interface
Parameters:
- STEP, 4: maximum right-shift per SHIFT cycle; legal range 1..28.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair.
- exp_a, exp_b  input  8  operand exponents (unsigned, biased).
- mantis_a, mantis_b  input  28  operand mantissas; bit 0 is the sticky position.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts the result.
- exp_out  output  8  common exponent, equal to the larger input exponent.
- mantis_big  output  28  mantissa of the larger-exponent operand, unshifted.
- mantis_small  output  28  aligned mantissa of the other operand.
- swap  output  1  1 when operand b has the strictly larger exponent.
- busy  output  1  state is not IDLE.

## Operation
- States: IDLE, COMPARE, SHIFT, DONE. Reset and flush both force IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register both operands and go to COMPARE.
- COMPARE:
  - If exp_a >= exp_b, operand a is big and swap=0. Otherwise operand b is big and swap=1.
  - Ties select a.
  - diff = big exponent − small exponent (8-bit unsigned, no wrap, since big >= small).
  - rem = min(diff, 28).
  - Register exp_out = big exponent.
  - rem==0: go to DONE. Otherwise go to SHIFT.
- SHIFT, each cycle:
  - s = min(rem, STEP).
  - m ← (m >> s), with bit 0 ORed with the OR-reduce of the s bits shifted out and with the old bit 0.
  - rem ← rem − s.
  - When rem reaches 0, go to DONE.
- DONE:
  - out_valid=1. All outputs hold stable until out_ready.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE; no same-cycle accept.
- Shift rules:
  - A shift of 28 or more yields 0x0000000 | (|m).
  - Nonzero input never aligns to an all-zero mantissa.
- in_valid outside IDLE is ignored and the inputs are not sampled.
- flush has priority over every transition, including a DONE handshake. Flushed results are discarded with no out_valid pulse.
- Output values:
  - Reset values: out_valid=0, exp_out=0, mantis_big=0, mantis_small=0, swap=0, busy=0.
  - in_ready=1, because it is decoded from state and the state is IDLE during and after reset.
  - in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).

## Timing
- Cycle 0 is the accept edge. COMPARE occupies cycle 1, and SHIFT occupies cycles 2..k+1, with k = ceil(min(diff,28)/STEP).
- out_valid first rises in cycle k+2. diff=0 therefore gives out_valid in cycle 2.
- Maximum latency is 2+ceil(28/STEP); for STEP=4 that is 9 cycles.
- Throughput: after the DONE handshake, IDLE is re-entered next cycle, so back-to-back pairs have at least k+4 cycles between accepts.
- Asynchronous reset mid-operation clears all state immediately. No partial result appears after rst_n deasserts.
- Flush in any state: IDLE on the next edge, and in_ready=1 in the following cycle.

## Test plan
- Basic alignment, STEP=4:
  - Stimulus: exp_a=0x85, mantis_a=0x8000000, exp_b=0x80, mantis_b=0x8000001, out_ready=1.
  - Response: out_valid in cycle 4, exp_out=0x85, mantis_big=0x8000000, mantis_small=0x0400001, swap=0.
- Saturated difference:
  - Stimulus: exp_a=0x10, mantis_a=0x0000010, exp_b=0x38, mantis_b=0x1234567.
  - Response: swap=1, exp_out=0x38, mantis_big=0x1234567, mantis_small=0x0000001, out_valid in cycle 9.
- Equal exponents:
  - Stimulus: exp_a=exp_b=0x7F, mantis_a=0x0000ABC, mantis_b=0x0000DEF.
  - Response: out_valid in cycle 2, swap=0, mantis_big=0x0000ABC, mantis_small=0x0000DEF.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, and drive new in_valid pairs meanwhile.
  - Response: outputs stable, in_ready=0, new pairs not captured; IDLE one cycle after out_ready=1.
- Flush and reset:
  - Flush stimulus: assert flush during SHIFT.
  - Flush response: next cycle IDLE, in_ready=1, no out_valid.
  - Reset stimulus: assert rst_n=0 mid-COMPARE.
  - Reset response: all outputs at reset values immediately.
- STEP sweep:
  - Stimulus: STEP ∈ {1,4,7,28}, diff ∈ {1,7,27,28,255}.
  - Response: mantis_small matches the one-shot sticky shift, and latency equals 2+ceil(min(diff,28)/STEP).

Source files
------------

// File: rtl/align_sequencer.sv
// Exponent-alignment controller: picks the larger-exponent operand and sticky-shifts the other by STEP bits/cycle.
// Latency 2+ceil(min(diff,28)/STEP) cycles from accept; holds result in DONE until out_ready, in_ready low while busy.
module align_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [27:0] mantis_a,
    input  logic [27:0] mantis_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [27:0] mantis_big,
    output logic [27:0] mantis_small,
    output logic        swap,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [4:0] STEP_W = 5'(STEP);
    localparam logic [4:0] MAX_SH = 5'd28;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  op_exp_a;
    logic [7:0]  op_exp_b;
    logic [27:0] op_man_a;
    logic [27:0] op_man_b;
    logic [4:0]  rem;

    logic        a_big;
    logic [7:0]  diff;
    logic [4:0]  rem_init;
    logic [4:0]  shamt;
    logic [27:0] lost_mask;
    logic        sticky;
    logic [27:0] shifted;

    // Ties select operand a; differences beyond the mantissa width saturate.
    always_comb begin
        a_big    = (op_exp_a >= op_exp_b);
        diff     = a_big ? (op_exp_a - op_exp_b) : (op_exp_b - op_exp_a);
        rem_init = (diff > 8'd28) ? MAX_SH : diff[4:0];
    end

    always_comb begin
        shamt     = (rem < STEP_W) ? rem : STEP_W;
        lost_mask = ~(28'hFFF_FFFF << shamt);
        sticky    = |(mantis_small & lost_mask);
        shifted   = (mantis_small >> shamt) | {27'd0, sticky};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = COMPARE;
                COMPARE: state_nxt = (rem_init == 5'd0) ? DONE : SHIFT;
                SHIFT:   if (rem <= STEP_W) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_exp_a     <= 8'd0;
            op_exp_b     <= 8'd0;
            op_man_a     <= 28'd0;
            op_man_b     <= 28'd0;
            rem          <= 5'd0;
            exp_out      <= 8'd0;
            mantis_big   <= 28'd0;
            mantis_small <= 28'd0;
            swap         <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_exp_a <= exp_a;
                        op_exp_b <= exp_b;
                        op_man_a <= mantis_a;
                        op_man_b <= mantis_b;
                    end
                end
                COMPARE: begin
                    swap         <= !a_big;
                    exp_out      <= a_big ? op_exp_a : op_exp_b;
                    mantis_big   <= a_big ? op_man_a : op_man_b;
                    mantis_small <= a_big ? op_man_b : op_man_a;
                    rem          <= rem_init;
                end
                SHIFT: begin
                    mantis_small <= shifted;
                    rem          <= rem - shamt;
                end
                default: begin
                end
            endcase
        end
    end

    // SHIFT is only ever entered or held with work left to do.
    a_shift_rem_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SHIFT) |-> (rem != 5'd0));

endmodule

// File: tb/tb_align_sequencer.sv
// Bench for align_sequencer: four instances (STEP 1/4/7/28) driven in lockstep, checked each cycle against a one-shot alignment model.
module tb_align_sequencer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [27:0] mantis_a;
    logic [27:0] mantis_b;

    logic        ir   [4];
    logic        ov   [4];
    logic [7:0]  eo   [4];
    logic [27:0] mbig [4];
    logic [27:0] msm  [4];
    logic        sw   [4];
    logic        bz   [4];

    int          cyc;
    int          total;
    int          bad;
    bit          chk_on;
    bit          pending   [4];
    int          lat       [4];
    int          first_cyc [4];
    logic [27:0] got_small [4];
    int          acc_edge;
    int          kill_edge;

    logic [7:0]  m_eo;
    logic [27:0] m_big;
    logic [27:0] m_sm;
    logic        m_sw;
    int          m_d;

    align_sequencer #(.STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .exp_a(exp_a), .exp_b(exp_b), .mantis_a(mantis_a), .mantis_b(mantis_b),
        .out_valid(ov[0]), .out_ready(out_ready), .exp_out(eo[0]), .mantis_big(mbig[0]),
        .mantis_small(msm[0]), .swap(sw[0]), .busy(bz[0]));

    align_sequencer #(.STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .exp_a(exp_a), .exp_b(exp_b), .mantis_a(mantis_a), .mantis_b(mantis_b),
        .out_valid(ov[1]), .out_ready(out_ready), .exp_out(eo[1]), .mantis_big(mbig[1]),
        .mantis_small(msm[1]), .swap(sw[1]), .busy(bz[1]));

    align_sequencer #(.STEP(7)) u_s7 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .exp_a(exp_a), .exp_b(exp_b), .mantis_a(mantis_a), .mantis_b(mantis_b),
        .out_valid(ov[2]), .out_ready(out_ready), .exp_out(eo[2]), .mantis_big(mbig[2]),
        .mantis_small(msm[2]), .swap(sw[2]), .busy(bz[2]));

    align_sequencer #(.STEP(28)) u_s28 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
        .exp_a(exp_a), .exp_b(exp_b), .mantis_a(mantis_a), .mantis_b(mantis_b),
        .out_valid(ov[3]), .out_ready(out_ready), .exp_out(eo[3]), .mantis_big(mbig[3]),
        .mantis_small(msm[3]), .swap(sw[3]), .busy(bz[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at cycle %0d: got 0x%0h expected 0x%0h", nm, idx, cyc, act, exp);
        end
    endtask

    function automatic int step_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 7;
            default: return 28;
        endcase
    endfunction

    // One-shot alignment: shift the smaller operand by the full difference, OR all lost bits into bit 0.
    function automatic void model(input logic [7:0] ea, input logic [7:0] eb,
                                  input logic [27:0] ma, input logic [27:0] mb,
                                  output logic [7:0] eo_m, output logic [27:0] big_m,
                                  output logic [27:0] sm_m, output logic sw_m, output int d);
        logic [27:0] m;
        logic        st;
        sw_m  = (eb > ea);
        eo_m  = sw_m ? eb : ea;
        big_m = sw_m ? mb : ma;
        m     = sw_m ? ma : mb;
        d     = sw_m ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
        if (d >= 28) begin
            sm_m = {27'd0, |m};
        end else begin
            sm_m = m >> d;
            st   = 1'b0;
            for (int b = 0; b < d; b++) st = st | m[b];
            sm_m[0] = sm_m[0] | st;
        end
    endfunction

    function automatic int latency(input int d, input int step);
        int r;
        r = (d > 28) ? 28 : d;
        return 2 + (r + step - 1) / step;
    endfunction

    // Per-cycle comparison against the model for every instance.
    always @(negedge clk) begin
        bit act;
        bit ev;
        if (rst_n && chk_on) begin
            if (kill_edge >= 0 && cyc >= kill_edge) begin
                for (int i = 0; i < 4; i++) pending[i] = 1'b0;
                kill_edge = -1;
            end
            for (int i = 0; i < 4; i++) begin
                act = pending[i] && (cyc >= acc_edge);
                ev  = act && ((cyc - acc_edge + 1) >= lat[i]);
                if (act && ov[i] && first_cyc[i] < 0) begin
                    first_cyc[i] = cyc - acc_edge + 1;
                    got_small[i] = msm[i];
                end
                chk("out_valid", i, ov[i], ev);
                chk("busy", i, bz[i], act);
                chk("in_ready", i, ir[i], !act);
                if (ev) begin
                    chk("exp_out", i, eo[i], m_eo);
                    chk("mantis_big", i, mbig[i], m_big);
                    chk("mantis_small", i, msm[i], m_sm);
                    chk("swap", i, sw[i], m_sw);
                    if (out_ready) pending[i] = 1'b0;
                end
            end
        end
    end

    task automatic launch(input logic [7:0] ea, input logic [7:0] eb,
                          input logic [27:0] ma, input logic [27:0] mb);
        @(posedge clk);
        #1;
        model(ea, eb, ma, mb, m_eo, m_big, m_sm, m_sw, m_d);
        exp_a    = ea;
        exp_b    = eb;
        mantis_a = ma;
        mantis_b = mb;
        in_valid = 1'b1;
        acc_edge = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            lat[i]       = latency(m_d, step_of(i));
            first_cyc[i] = -1;
            got_small[i] = 28'd0;
            pending[i]   = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((pending[0] || pending[1] || pending[2] || pending[3]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 0, (n < budget), 1);
        for (int i = 0; i < 4; i++) pending[i] = 1'b0;
    endtask

    task automatic chk_reset_vals();
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_valid", i, ov[i], 0);
            chk("rst_exp_out", i, eo[i], 0);
            chk("rst_mantis_big", i, mbig[i], 0);
            chk("rst_mantis_small", i, msm[i], 0);
            chk("rst_swap", i, sw[i], 0);
            chk("rst_busy", i, bz[i], 0);
            chk("rst_in_ready", i, ir[i], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  t_eo;
        logic [27:0] t_big;
        logic [27:0] t_sm;
        logic        t_sw;
        int          t_d;
        int          n;

        total = 0; bad = 0; chk_on = 1'b0; kill_edge = -1; acc_edge = 0;
        for (int i = 0; i < 4; i++) begin
            pending[i] = 1'b0; lat[i] = 0; first_cyc[i] = -1; got_small[i] = 28'd0;
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_a = 8'd0; exp_b = 8'd0; mantis_a = 28'd0; mantis_b = 28'd0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // Hand-computed pins for the model itself.
        model(8'h85, 8'h80, 28'h8000000, 28'h8000001, t_eo, t_big, t_sm, t_sw, t_d);
        chk("pin_basic_eo", 0, t_eo, 32'h85);
        chk("pin_basic_small", 0, t_sm, 32'h0400001);
        chk("pin_basic_swap", 0, t_sw, 0);
        chk("pin_basic_lat", 0, latency(t_d, 4), 4);
        model(8'h10, 8'h38, 28'h0000010, 28'h1234567, t_eo, t_big, t_sm, t_sw, t_d);
        chk("pin_sat_eo", 0, t_eo, 32'h38);
        chk("pin_sat_big", 0, t_big, 32'h1234567);
        chk("pin_sat_small", 0, t_sm, 32'h1);
        chk("pin_sat_swap", 0, t_sw, 1);
        chk("pin_sat_lat", 0, latency(t_d, 4), 9);
        model(8'h7F, 8'h7F, 28'h0000ABC, 28'h0000DEF, t_eo, t_big, t_sm, t_sw, t_d);
        chk("pin_eq_small", 0, t_sm, 32'hDEF);
        chk("pin_eq_lat", 0, latency(t_d, 4), 2);

        // Test-plan vectors with literal latency/result checks on the STEP=4 instance.
        launch(8'h85, 8'h80, 28'h8000000, 28'h8000001);
        wait_idle(60);
        chk("basic_first_valid_cycle", 1, first_cyc[1], 4);
        chk("basic_small_literal", 1, got_small[1], 32'h0400001);

        launch(8'h10, 8'h38, 28'h0000010, 28'h1234567);
        wait_idle(60);
        chk("sat_first_valid_cycle", 1, first_cyc[1], 9);
        chk("sat_small_literal", 1, got_small[1], 32'h1);

        launch(8'h7F, 8'h7F, 28'h0000ABC, 28'h0000DEF);
        wait_idle(60);
        chk("eq_first_valid_cycle", 1, first_cyc[1], 2);

        // Difference sweep: 1, 7, 27, 28, 255.
        launch(8'h81, 8'h80, 28'h1234567, 28'h0000003);
        wait_idle(60);
        launch(8'h10, 8'h17, 28'hABCDEF1, 28'h5555555);
        wait_idle(60);
        launch(8'h40, 8'h25, 28'h7777777, 28'h8000000);
        wait_idle(60);
        launch(8'h00, 8'h1C, 28'h0000001, 28'hFEDCBA9);
        wait_idle(60);
        chk("d28_step1_cycle", 0, first_cyc[0], 30);
        launch(8'hFF, 8'h00, 28'h0F0F0F0, 28'h0000000);
        wait_idle(60);

        // Backpressure: hold DONE, offer new pairs, then release.
        out_ready = 1'b0;
        launch(8'h85, 8'h80, 28'h8000000, 28'h8000001);
        n = 0;
        while ((first_cyc[0] < 0 || first_cyc[1] < 0 || first_cyc[2] < 0 || first_cyc[3] < 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("bp_all_valid", 0, (n < 60), 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; exp_a = 8'h01; exp_b = 8'hF0;
            mantis_a = 28'h1111111; mantis_b = 28'h2222222;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(5);

        // Flush during SHIFT of the STEP=4 instance.
        out_ready = 1'b0;
        launch(8'h20, 8'h3B, 28'hFFFFFFF, 28'h9ABCDEF);
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        kill_edge = cyc + 1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 1, ir[1], 1);
        chk("flush_out_valid", 1, ov[1], 0);
        repeat (30) @(negedge clk);

        // Asynchronous reset while in COMPARE.
        launch(8'h50, 8'h4D, 28'h1000000, 28'h0ABCDEF);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) pending[i] = 1'b0;
        #1 chk_reset_vals();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        launch(8'h90, 8'h93, 28'h00000F1, 28'h0F00000);
        wait_idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
